// File: rtl/tx_stream_fifo_pkg.sv
// Shared helpers for tx_stream_fifo: wrapping pointer increment, EOP bit position
// and parameter legality predicates used by elaboration-time checks.
package tx_fifo_pkg;

  // Wrap explicitly at depth-1 so any depth works, not just powers of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned eop_bit(input int unsigned width);
    return width - 1;
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return width >= 2;
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return depth >= 2;
  endfunction

  function automatic bit af_ok(input int unsigned af_level, input int unsigned depth);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/tx_stream_fifo_if.sv
// Valid/ready bus between TX framer (master) and tx_stream_fifo (slave), plus
// flush and occupancy status; the downstream half is driven by the FIFO.
interface tx_stream_fifo_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             FLUSH;
  logic [WIDTH-1:0] DATA_UP;
  logic             VALID_UP;
  logic             READY_UP;
  logic [WIDTH-1:0] DATA_DOWN;
  logic             VALID_DOWN;
  logic             READY_DOWN;
  logic [CW-1:0]    COUNT;
  logic             ALMOST_FULL;

  modport master (
    output FLUSH, DATA_UP, VALID_UP, READY_DOWN,
    input  READY_UP, DATA_DOWN, VALID_DOWN, COUNT, ALMOST_FULL
  );

  modport slave (
    input  FLUSH, DATA_UP, VALID_UP, READY_DOWN,
    output READY_UP, DATA_DOWN, VALID_DOWN, COUNT, ALMOST_FULL
  );
endinterface

// File: rtl/tx_stream_fifo_ptr.sv
// Wrapping 0..DEPTH-1 pointer register; 1-cycle update, clear beats increment.
// No backpressure of its own: the parent decides when to advance.
module tx_fifo_ptr
  import tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = PW'(ptr_inc(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/tx_stream_fifo.sv
// Any-depth fall-through FIFO, write-to-head latency 1 cycle; READY_UP = not full, no READY_DOWN path.
// `define TX_STREAM_FIFO_PKT_EN holds VALID_DOWN until a full packet (EOP = top bit) is stored.
module tx_stream_fifo
  import tx_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic             CLK,
  input  logic             RESET,
  tx_stream_fifo_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("tx_stream_fifo: WIDTH must be >= 2");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("tx_stream_fifo: DEPTH must be >= 2");
  end
  if (!af_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
    $error("tx_stream_fifo: AF_LEVEL must be in 1..DEPTH");
  end

  typedef logic [WIDTH-1:0] word_t;

  word_t         mem_q [DEPTH];
  word_t         mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          valid_down;
  logic          wr_en;
  logic          rd_en;
  word_t         head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr];

  // Flush wins: any transfer presented alongside it is dropped.
  assign wr_en = bus.VALID_UP && !full && !bus.FLUSH;
  assign rd_en = valid_down && bus.READY_DOWN && !bus.FLUSH;

  tx_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (bus.FLUSH),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  tx_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (bus.FLUSH),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = bus.DATA_UP;
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.FLUSH) begin
      count_d = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

`ifdef TX_STREAM_FIFO_PKT_EN
  localparam int unsigned EOP = eop_bit(WIDTH);

  logic [CW-1:0] pkt_cnt_q;
  logic [CW-1:0] pkt_cnt_d;
  logic          eop_wr;
  logic          eop_rd;

  assign eop_wr = wr_en && bus.DATA_UP[EOP];
  assign eop_rd = rd_en && head[EOP];

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (bus.FLUSH) begin
      pkt_cnt_d = '0;
    end else begin
      case ({eop_wr, eop_rd})
        2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
        2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
        default: pkt_cnt_d = pkt_cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // A full FIFO with no EOP inside must release anyway, or it never drains.
  assign valid_down = !empty && ((pkt_cnt_q != '0) || full);
`else
  assign valid_down = !empty;
`endif

  assign bus.READY_UP    = !full;
  assign bus.VALID_DOWN  = valid_down;
  assign bus.DATA_DOWN   = head;
  assign bus.COUNT       = count_q;
  assign bus.ALMOST_FULL = (count_q >= AF_CNT);

endmodule

// File: tb/tb_tx_stream_fifo.sv
// Directed bench for tx_stream_fifo: DEPTH=4 main instance, DEPTH=5 wrap instance.
// Packet-mode checks replace the streaming fill/flush checks when TX_STREAM_FIFO_PKT_EN is defined.
module tb_tx_stream_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tx_stream_fifo_if #(.WIDTH(10), .DEPTH(4)) bus4 ();
  tx_stream_fifo_if #(.WIDTH(10), .DEPTH(5)) bus5 ();

  tx_stream_fifo #(.WIDTH(10), .DEPTH(4), .AF_LEVEL(3)) u_dut4 (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus4)
  );

  tx_stream_fifo #(.WIDTH(10), .DEPTH(5)) u_dut5 (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus5)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_outs4(input string tag, input logic rdy, input logic vld,
                             input logic [9:0] dat, input logic [2:0] cnt, input logic af);
    check_eq({tag, "_rdy"}, 32'(bus4.READY_UP), 32'(rdy));
    check_eq({tag, "_vld"}, 32'(bus4.VALID_DOWN), 32'(vld));
    check_eq({tag, "_dat"}, 32'(bus4.DATA_DOWN), 32'(dat));
    check_eq({tag, "_cnt"}, 32'(bus4.COUNT), 32'(cnt));
    check_eq({tag, "_af"}, 32'(bus4.ALMOST_FULL), 32'(af));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus4.FLUSH = 1'b0; bus4.DATA_UP = '0; bus4.VALID_UP = 1'b0; bus4.READY_DOWN = 1'b0;
    bus5.FLUSH = 1'b0; bus5.DATA_UP = '0; bus5.VALID_UP = 1'b0; bus5.READY_DOWN = 1'b0;
    #3;
    check_outs4("reset", 1'b1, 1'b0, 10'h000, 3'd0, 1'b0);
    check_eq("reset5_rdy", 32'(bus5.READY_UP), 32'd1);
    check_eq("reset5_vld", 32'(bus5.VALID_DOWN), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs4("idle", 1'b1, 1'b0, 10'h000, 3'd0, 1'b0);
    end

`ifndef TX_STREAM_FIFO_PKT_EN
    // Fill to full with the consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      bus4.DATA_UP = 10'(i);
      bus4.VALID_UP = 1'b1;
      tick();
      check_outs4("fill", (i < 4), 1'b1, 10'h001, 3'(i), (i >= 3));
    end
    bus4.DATA_UP = 10'h005;
    tick();
    tick();
    check_outs4("held", 1'b0, 1'b1, 10'h001, 3'd4, 1'b1);
    bus4.VALID_UP = 1'b0;
    bus4.READY_DOWN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_dat", 32'(bus4.DATA_DOWN), 32'(i));
      check_eq("drain_vld", 32'(bus4.VALID_DOWN), 32'd1);
      tick();
      check_eq("drain_cnt", 32'(bus4.COUNT), 32'(4 - i));
      check_eq("drain_rdy", 32'(bus4.READY_UP), 32'd1);
      check_eq("drain_af", 32'(bus4.ALMOST_FULL), 32'((4 - i) >= 3));
    end
    check_eq("drain_empty", 32'(bus4.VALID_DOWN), 32'd0);

    // Write into empty FIFO with READY_DOWN already high: no same-cycle read.
    bus4.DATA_UP = 10'h2AA;
    bus4.VALID_UP = 1'b1;
    tick();
    bus4.VALID_UP = 1'b0;
    check_outs4("emptywr", 1'b1, 1'b1, 10'h2AA, 3'd1, 1'b0);
    tick();
    check_eq("emptywr_rd_cnt", 32'(bus4.COUNT), 32'd0);
    check_eq("emptywr_rd_vld", 32'(bus4.VALID_DOWN), 32'd0);
    bus4.READY_DOWN = 1'b0;

    // Flush at COUNT=3 together with a write of 0x155.
    for (int i = 0; i < 3; i++) begin
      bus4.DATA_UP = 10'(10'h00A + i);
      bus4.VALID_UP = 1'b1;
      tick();
    end
    check_eq("preflush_cnt", 32'(bus4.COUNT), 32'd3);
    check_eq("preflush_af", 32'(bus4.ALMOST_FULL), 32'd1);
    bus4.DATA_UP = 10'h155;
    bus4.FLUSH = 1'b1;
    tick();
    bus4.FLUSH = 1'b0;
    bus4.VALID_UP = 1'b0;
    check_eq("flush_cnt", 32'(bus4.COUNT), 32'd0);
    check_eq("flush_vld", 32'(bus4.VALID_DOWN), 32'd0);
    check_eq("flush_rdy", 32'(bus4.READY_UP), 32'd1);
    check_eq("flush_af", 32'(bus4.ALMOST_FULL), 32'd0);
    tick();
    check_eq("flush_idle_cnt", 32'(bus4.COUNT), 32'd0);
    bus4.DATA_UP = 10'h00D;
    bus4.VALID_UP = 1'b1;
    tick();
    bus4.VALID_UP = 1'b0;
    check_eq("postflush_dat", 32'(bus4.DATA_DOWN), 32'h00D);
    check_eq("postflush_cnt", 32'(bus4.COUNT), 32'd1);
    bus4.READY_DOWN = 1'b1;
    tick();
    bus4.READY_DOWN = 1'b0;
    check_eq("postflush_vld", 32'(bus4.VALID_DOWN), 32'd0);
    check_eq("postflush_cnt0", 32'(bus4.COUNT), 32'd0);
`else
    begin
      logic [9:0] pkt_words [3];
      pkt_words[0] = 10'h010;
      pkt_words[1] = 10'h011;
      pkt_words[2] = 10'h212;
      // VALID_DOWN stays low until the EOP word lands.
      for (int i = 0; i < 3; i++) begin
        bus4.DATA_UP = pkt_words[i];
        bus4.VALID_UP = 1'b1;
        tick();
        check_eq("pkt_vld", 32'(bus4.VALID_DOWN), 32'(i == 2));
        check_eq("pkt_cnt", 32'(bus4.COUNT), 32'(i + 1));
      end
      bus4.VALID_UP = 1'b0;
      bus4.READY_DOWN = 1'b1;
      for (int i = 0; i < 3; i++) begin
        check_eq("pkt_rd_dat", 32'(bus4.DATA_DOWN), 32'(pkt_words[i]));
        check_eq("pkt_rd_vld", 32'(bus4.VALID_DOWN), 32'd1);
        tick();
      end
      bus4.READY_DOWN = 1'b0;
      check_eq("pkt_done_vld", 32'(bus4.VALID_DOWN), 32'd0);
      check_eq("pkt_done_cnt", 32'(bus4.COUNT), 32'd0);
    end

    // Four non-EOP words: released only once full.
    for (int i = 0; i < 4; i++) begin
      bus4.DATA_UP = 10'(10'h020 + i);
      bus4.VALID_UP = 1'b1;
      tick();
      check_eq("ct_vld", 32'(bus4.VALID_DOWN), 32'(i == 3));
      check_eq("ct_cnt", 32'(bus4.COUNT), 32'(i + 1));
    end
    bus4.VALID_UP = 1'b0;
    check_eq("ct_head", 32'(bus4.DATA_DOWN), 32'h020);
    bus4.READY_DOWN = 1'b1;
    tick();
    bus4.READY_DOWN = 1'b0;
    check_eq("ct_after1_cnt", 32'(bus4.COUNT), 32'd3);
    check_eq("ct_after1_vld", 32'(bus4.VALID_DOWN), 32'd0);
    bus4.DATA_UP = 10'h224;
    bus4.VALID_UP = 1'b1;
    tick();
    bus4.VALID_UP = 1'b0;
    check_eq("ct_eop_cnt", 32'(bus4.COUNT), 32'd4);
    check_eq("ct_eop_vld", 32'(bus4.VALID_DOWN), 32'd1);
    bus4.READY_DOWN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("ct_rd_dat", 32'(bus4.DATA_DOWN), (i == 4) ? 32'h224 : 32'(32'h020 + i));
      check_eq("ct_rd_vld", 32'(bus4.VALID_DOWN), 32'd1);
      tick();
    end
    bus4.READY_DOWN = 1'b0;
    check_eq("ct_done_vld", 32'(bus4.VALID_DOWN), 32'd0);
    check_eq("ct_done_cnt", 32'(bus4.COUNT), 32'd0);

    // Flush must also clear the packet count.
    bus4.DATA_UP = 10'h2FF;
    bus4.VALID_UP = 1'b1;
    tick();
    bus4.VALID_UP = 1'b0;
    check_eq("pflush_pre_vld", 32'(bus4.VALID_DOWN), 32'd1);
    bus4.FLUSH = 1'b1;
    tick();
    bus4.FLUSH = 1'b0;
    check_eq("pflush_cnt", 32'(bus4.COUNT), 32'd0);
    bus4.DATA_UP = 10'h001;
    bus4.VALID_UP = 1'b1;
    tick();
    bus4.VALID_UP = 1'b0;
    check_eq("pflush_post_cnt", 32'(bus4.COUNT), 32'd1);
    check_eq("pflush_post_vld", 32'(bus4.VALID_DOWN), 32'd0);
    bus4.FLUSH = 1'b1;
    tick();
    bus4.FLUSH = 1'b0;
    check_eq("pflush_clr_cnt", 32'(bus4.COUNT), 32'd0);
`endif

    // DEPTH=5: 23 words streamed with overlap; every word carries bit 9 so packet mode matches.
    for (int c = 0; c < 25; c++) begin
      bus5.VALID_UP = (c < 23);
      bus5.DATA_UP = 10'(10'h300 + c);
      bus5.READY_DOWN = (c >= 2);
      #1;
      if (c < 23) check_eq("wrap_rdy", 32'(bus5.READY_UP), 32'd1);
      check_eq("wrap_vld", 32'(bus5.VALID_DOWN), 32'(c != 0));
      if (c >= 2) check_eq("wrap_dat", 32'(bus5.DATA_DOWN), 32'(32'h300 + c - 2));
      @(posedge clk);
      #1;
      check_eq("wrap_cnt", 32'(bus5.COUNT), 32'(((c < 23) ? c + 1 : 23) - ((c >= 2) ? c - 1 : 0)));
    end
    bus5.VALID_UP = 1'b0;
    bus5.READY_DOWN = 1'b0;
    check_eq("wrap_end_vld", 32'(bus5.VALID_DOWN), 32'd0);

    // Asynchronous reset between clock edges.
    bus4.DATA_UP = 10'h0C3;
    bus4.VALID_UP = 1'b1;
    tick();
    bus4.DATA_UP = 10'h3C3;
    tick();
    bus4.VALID_UP = 1'b0;
    check_eq("arst_pre_cnt", 32'(bus4.COUNT), 32'd2);
    check_eq("arst_pre_dat", 32'(bus4.DATA_DOWN), 32'h0C3);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs4("arst", 1'b1, 1'b0, 10'h000, 3'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check_outs4("arst_post", 1'b1, 1'b0, 10'h000, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
